// File: rtl/rom_mc_scan.sv
// rom_mc_scan: multi-channel read-only memory sharing a single read port.
// Requesters are served round-robin, one read per cycle, with a fixed-latency
// response pulse. A built-in scan sums every word for boot-time integrity checks.
module rom_mc_scan #(
  parameter int    WIDTH     = 16,
  parameter int    DEPTH     = 1024,
  parameter int    NUM_CH    = 2,
  parameter int    OUT_REG   = 1,
  parameter string INIT_FILE = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int   SW        = WIDTH + AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*AW-1:0]    req_addr,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH-1:0]       rsp_valid,
  output logic [NUM_CH*WIDTH-1:0] rsp_data,
  output logic [NUM_CH-1:0]       rsp_err,
  input  logic                    scan_start,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic [SW-1:0]           scan_sum
);

  localparam int          PW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          LAT      = 1 + OUT_REG;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  // Last SCAN cycle: the final word has been accumulated one cycle earlier.
  localparam logic [AW:0] LP_LAST  = (AW+1)'(DEPTH + LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_ptr;
  logic [AW:0]        r_scan_cnt;
  logic [SW-1:0]      r_scan_sum;
  logic [NUM_CH-1:0]  r_rsp_valid;
  logic [NUM_CH-1:0]  r_rsp_err;
  logic [NUM_CH*WIDTH-1:0] r_rsp_data;

  logic               w_scan_accept;
  logic               w_arb_en;
  logic               w_grant_found;
  logic [PW-1:0]      w_grant_ch;

  logic               w_iss_valid;
  logic               w_iss_scan;
  logic [PW-1:0]      w_iss_ch;
  logic [AW-1:0]      w_iss_addr;
  logic               w_iss_err;
  logic [AW-1:0]      w_rd_addr;
  logic [WIDTH-1:0]   w_rom_word;
  logic [WIDTH-1:0]   w_iss_data;

  logic               w_fin_valid;
  logic               w_fin_scan;
  logic [PW-1:0]      w_fin_ch;
  logic               w_fin_err;
  logic [WIDTH-1:0]   w_fin_data;

  // Channel index base+off, wrapped into 0..NUM_CH-1.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return sum[PW-1:0];
  endfunction

  // A scan request in IDLE takes priority over any pending channel request.
  assign w_scan_accept = (r_state == ST_IDLE) && scan_start;
  assign w_arb_en      = (r_state == ST_IDLE) && !scan_start;

  // Round-robin search from the pointer upward with wrap; at most one grant.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_ch    = '0;
    req_ready     = '0;
    if (w_arb_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_grant_found && req_valid[f_wrap(r_ptr, k)]) begin
          w_grant_found = 1'b1;
          w_grant_ch    = f_wrap(r_ptr, k);
        end
      end
      if (w_grant_found) req_ready[w_grant_ch] = 1'b1;
    end
  end

  // Pointer moves just past the granted channel; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_found) begin
      r_ptr <= f_wrap(w_grant_ch, 1);
    end
  end

  // Select what uses the read port this cycle: the scan walker or the granted channel.
  always_comb begin
    w_iss_valid = 1'b0;
    w_iss_scan  = 1'b0;
    w_iss_ch    = '0;
    w_iss_addr  = '0;
    if ((r_state == ST_SCAN) && (r_scan_cnt < LP_DEPTH)) begin
      w_iss_valid = 1'b1;
      w_iss_scan  = 1'b1;
      w_iss_addr  = r_scan_cnt[AW-1:0];
    end else if (w_grant_found) begin
      w_iss_valid = 1'b1;
      w_iss_ch    = w_grant_ch;
      w_iss_addr  = req_addr[w_grant_ch*AW +: AW];
    end
  end

  // Out-of-range addresses never reach the array; they read back as zero.
  assign w_iss_err  = ({1'b0, w_iss_addr} >= LP_DEPTH);
  assign w_rd_addr  = w_iss_err ? '0 : w_iss_addr;
  assign w_iss_data = w_iss_err ? '0 : w_rom_word;

  assign w_rom_word = WIDTH'(w_rd_addr);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             r_s1_valid;
      logic             r_s1_scan;
      logic [PW-1:0]    r_s1_ch;
      logic             r_s1_err;
      logic [WIDTH-1:0] r_s1_data;

      // Extra pipeline stage carrying the tag, error flag and word together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_scan  <= 1'b0;
          r_s1_ch    <= '0;
          r_s1_err   <= 1'b0;
          r_s1_data  <= '0;
        end else begin
          r_s1_valid <= w_iss_valid;
          r_s1_scan  <= w_iss_scan;
          r_s1_ch    <= w_iss_ch;
          r_s1_err   <= w_iss_err;
          r_s1_data  <= w_iss_data;
        end
      end

      assign w_fin_valid = r_s1_valid;
      assign w_fin_scan  = r_s1_scan;
      assign w_fin_ch    = r_s1_ch;
      assign w_fin_err   = r_s1_err;
      assign w_fin_data  = r_s1_data;
    end else begin : g_no_out_reg
      assign w_fin_valid = w_iss_valid;
      assign w_fin_scan  = w_iss_scan;
      assign w_fin_ch    = w_iss_ch;
      assign w_fin_err   = w_iss_err;
      assign w_fin_data  = w_iss_data;
    end
  endgenerate

  // Response registers: one-cycle pulse per channel, data slice held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      if (w_fin_valid && !w_fin_scan) begin
        r_rsp_valid[w_fin_ch]                <= 1'b1;
        r_rsp_err[w_fin_ch]                  <= w_fin_err;
        r_rsp_data[w_fin_ch*WIDTH +: WIDTH]  <= w_fin_data;
      end
    end
  end

  // Checksum accumulator: cleared when a scan starts, adds each returning scan word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_sum <= '0;
    end else if (w_scan_accept) begin
      r_scan_sum <= '0;
    end else if (w_fin_valid && w_fin_scan) begin
      r_scan_sum <= r_scan_sum + SW'(w_fin_data);
    end
  end

  // Scan cycle counter doubles as the issue address and the completion timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (w_scan_accept) begin
      r_scan_cnt <= '0;
    end else if (r_state == ST_SCAN) begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scan FSM next state: IDLE -> SCAN -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (scan_start) w_state_next = ST_SCAN;
      ST_SCAN: if (r_scan_cnt == LP_LAST) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign scan_sum  = r_scan_sum;
  assign scan_busy = (r_state != ST_IDLE);
  assign scan_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_rom_mc_scan.sv
// tb_rom_mc_scan: directed bench for rom_mc_scan. Three instances share stimulus:
// defaults (latency 2), DEPTH=1000 (out-of-range path), OUT_REG=0 (latency 1).
module tb_rom_mc_scan;

  localparam int AW = 10;
  localparam int SW = 26;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reqValid;
  logic [19:0] reqAddr;
  logic        scanStart;

  logic [1:0]    aReqReady, aRspValid, aRspErr;
  logic [31:0]   aRspData;
  logic          aScanBusy, aScanDone;
  logic [SW-1:0] aScanSum;

  logic [1:0]    bReqReady, bRspValid, bRspErr;
  logic [31:0]   bRspData;
  logic          bScanBusy, bScanDone;
  logic [SW-1:0] bScanSum;

  logic [1:0]    cReqReady, cRspValid, cRspErr;
  logic [31:0]   cRspData;
  logic          cScanBusy, cScanDone;
  logic [SW-1:0] cScanSum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_mc_scan u_dutA (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_addr(reqAddr),
    .req_ready(aReqReady), .rsp_valid(aRspValid), .rsp_data(aRspData), .rsp_err(aRspErr),
    .scan_start(scanStart), .scan_busy(aScanBusy), .scan_done(aScanDone), .scan_sum(aScanSum)
  );

  rom_mc_scan #(.DEPTH(1000)) u_dutB (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_addr(reqAddr),
    .req_ready(bReqReady), .rsp_valid(bRspValid), .rsp_data(bRspData), .rsp_err(bRspErr),
    .scan_start(scanStart), .scan_busy(bScanBusy), .scan_done(bScanDone), .scan_sum(bScanSum)
  );

  rom_mc_scan #(.OUT_REG(0)) u_dutC (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_addr(reqAddr),
    .req_ready(cReqReady), .rsp_valid(cRspValid), .rsp_data(cRspData), .rsp_err(cRspErr),
    .scan_start(scanStart), .scan_busy(cScanBusy), .scan_done(cScanDone), .scan_sum(cScanSum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n     = 1'b0;
    reqValid  = '0;
    reqAddr   = '0;
    scanStart = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    reqValid  = '0;
    reqAddr   = '0;
    scanStart = 1'b0;
    #1;
    checks++; if (aReqReady !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 00", aReqReady); end
    checks++; if (aRspValid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", aRspValid); end
    checks++; if (aRspErr !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_err: got %b expected 00", aRspErr); end
    checks++; if (aRspData !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", aRspData); end
    checks++; if ({aScanBusy, aScanDone} !== 2'b00) begin failures++; $display("[TB] FAIL reset_scan_flags: got %b expected 00", {aScanBusy, aScanDone}); end
    checks++; if (aScanSum !== '0) begin failures++; $display("[TB] FAIL reset_scan_sum: got %0d expected 0", aScanSum); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (aScanBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_busy: got %b expected 0", aScanBusy); end
  endtask

  task automatic test_single_read();
    applyReset();
    reqValid = 2'b01;
    reqAddr  = {10'd0, 10'd5};
    #1;
    checks++; if (aReqReady !== 2'b01) begin failures++; $display("[TB] FAIL single_ready: got %b expected 01", aReqReady); end
    checks++; if (cReqReady !== 2'b01) begin failures++; $display("[TB] FAIL single_ready_lat1: got %b expected 01", cReqReady); end
    tick();
    reqValid = 2'b00;
    checks++; if (aRspValid !== 2'b00) begin failures++; $display("[TB] FAIL single_early_valid: got %b expected 00", aRspValid); end
    checks++; if (cRspValid !== 2'b01) begin failures++; $display("[TB] FAIL lat1_valid: got %b expected 01", cRspValid); end
    checks++; if (cRspData[15:0] !== 16'd5) begin failures++; $display("[TB] FAIL lat1_data: got %0d expected 5", cRspData[15:0]); end
    tick();
    checks++; if (aRspValid !== 2'b01) begin failures++; $display("[TB] FAIL single_valid: got %b expected 01", aRspValid); end
    checks++; if (aRspData[15:0] !== 16'd5) begin failures++; $display("[TB] FAIL single_data: got %0d expected 5", aRspData[15:0]); end
    checks++; if (aRspErr !== 2'b00) begin failures++; $display("[TB] FAIL single_err: got %b expected 00", aRspErr); end
    checks++; if (cRspValid !== 2'b00) begin failures++; $display("[TB] FAIL lat1_pulse_end: got %b expected 00", cRspValid); end
    tick();
    checks++; if (aRspValid !== 2'b00) begin failures++; $display("[TB] FAIL single_pulse_end: got %b expected 00", aRspValid); end
    checks++; if (aRspData[15:0] !== 16'd5) begin failures++; $display("[TB] FAIL single_data_held: got %0d expected 5", aRspData[15:0]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] expReady;
    applyReset();
    reqValid = 2'b11;
    reqAddr  = {10'd20, 10'd10};
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (aReqReady !== expReady) begin failures++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, aReqReady, expReady); end
      checks++;
      if (i < 2) begin
        if (aRspValid !== 2'b00) begin failures++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 00", i, aRspValid); end
      end else begin
        if (aRspValid !== expReady) begin failures++; $display("[TB] FAIL rr_valid[%0d]: got %b expected %b", i, aRspValid, expReady); end
      end
      if (i >= 3) begin
        checks++; if (aRspData !== {16'd20, 16'd10}) begin failures++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", i, aRspData, {16'd20, 16'd10}); end
      end
    end
    reqValid = 2'b00;
  endtask

  task automatic test_out_of_range();
    applyReset();
    reqValid = 2'b10;
    reqAddr  = {10'd1000, 10'd0};
    #1;
    checks++; if (bReqReady !== 2'b10) begin failures++; $display("[TB] FAIL oor_ready: got %b expected 10", bReqReady); end
    tick();
    reqValid = 2'b00;
    tick();
    checks++; if (bRspValid !== 2'b10) begin failures++; $display("[TB] FAIL oor_valid: got %b expected 10", bRspValid); end
    checks++; if (bRspErr !== 2'b10) begin failures++; $display("[TB] FAIL oor_err: got %b expected 10", bRspErr); end
    checks++; if (bRspData[31:16] !== 16'd0) begin failures++; $display("[TB] FAIL oor_data: got %0d expected 0", bRspData[31:16]); end
    checks++; if (aRspErr !== 2'b00) begin failures++; $display("[TB] FAIL inrange1024_err: got %b expected 00", aRspErr); end
    checks++; if (aRspData[31:16] !== 16'd1000) begin failures++; $display("[TB] FAIL inrange1024_data: got %0d expected 1000", aRspData[31:16]); end
    reqValid = 2'b10;
    reqAddr  = {10'd999, 10'd0};
    #1;
    tick();
    reqValid = 2'b00;
    tick();
    checks++; if (bRspValid !== 2'b10) begin failures++; $display("[TB] FAIL last_valid: got %b expected 10", bRspValid); end
    checks++; if (bRspErr !== 2'b00) begin failures++; $display("[TB] FAIL last_err: got %b expected 00", bRspErr); end
    checks++; if (bRspData[31:16] !== 16'd999) begin failures++; $display("[TB] FAIL last_data: got %0d expected 999", bRspData[31:16]); end
  endtask

  task automatic test_scan();
    int aDoneAt = -1;
    int bDoneAt = -1;
    int cDoneAt = -1;
    int busyCnt = 0;
    applyReset();
    scanStart = 1'b1;
    #1;
    tick();
    scanStart = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      if (n > 0) tick();
      if (aScanBusy && !aScanDone && aDoneAt < 0) busyCnt++;
      if (aScanDone && aDoneAt < 0) aDoneAt = n;
      if (bScanDone && bDoneAt < 0) bDoneAt = n;
      if (cScanDone && cDoneAt < 0) cDoneAt = n;
      if (aDoneAt >= 0 && bDoneAt >= 0 && cDoneAt >= 0) break;
    end
    checks++; if (aDoneAt !== 1026) begin failures++; $display("[TB] FAIL scan_done_time: got %0d expected 1026", aDoneAt); end
    checks++; if (busyCnt !== 1026) begin failures++; $display("[TB] FAIL scan_busy_cycles: got %0d expected 1026", busyCnt); end
    checks++; if (bDoneAt !== 1002) begin failures++; $display("[TB] FAIL scan_done_time_d1000: got %0d expected 1002", bDoneAt); end
    checks++; if (cDoneAt !== 1025) begin failures++; $display("[TB] FAIL scan_done_time_lat1: got %0d expected 1025", cDoneAt); end
    checks++; if (aScanSum !== 26'd523776) begin failures++; $display("[TB] FAIL scan_sum: got %0d expected 523776", aScanSum); end
    checks++; if (bScanSum !== 26'd499500) begin failures++; $display("[TB] FAIL scan_sum_d1000: got %0d expected 499500", bScanSum); end
    checks++; if (cScanSum !== 26'd523776) begin failures++; $display("[TB] FAIL scan_sum_lat1: got %0d expected 523776", cScanSum); end
    tick();
    checks++; if ({aScanBusy, aScanDone} !== 2'b00) begin failures++; $display("[TB] FAIL scan_after_done: got %b expected 00", {aScanBusy, aScanDone}); end
    repeat (5) tick();
    checks++; if (aScanSum !== 26'd523776) begin failures++; $display("[TB] FAIL scan_sum_held: got %0d expected 523776", aScanSum); end
  endtask

  task automatic test_req_during_scan();
    int grantedAt = -1;
    applyReset();
    reqValid  = 2'b01;
    reqAddr   = {10'd0, 10'd7};
    scanStart = 1'b1;
    #1;
    checks++; if (aReqReady !== 2'b00) begin failures++; $display("[TB] FAIL scan_wins_ready: got %b expected 00", aReqReady); end
    tick();
    scanStart = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      if (n > 0) tick();
      if (aReqReady[0]) begin
        grantedAt = n;
        break;
      end
    end
    checks++; if (grantedAt !== 1027) begin failures++; $display("[TB] FAIL busy_grant_time: got %0d expected 1027", grantedAt); end
    tick();
    reqValid = 2'b00;
    checks++; if (aRspValid !== 2'b00) begin failures++; $display("[TB] FAIL busy_rsp_early: got %b expected 00", aRspValid); end
    tick();
    checks++; if (aRspValid !== 2'b01) begin failures++; $display("[TB] FAIL busy_rsp_valid: got %b expected 01", aRspValid); end
    checks++; if (aRspData[15:0] !== 16'd7) begin failures++; $display("[TB] FAIL busy_rsp_data: got %0d expected 7", aRspData[15:0]); end
  endtask

  task automatic test_reset_mid_scan();
    int doneAt = -1;
    scanStart = 1'b1;
    #1;
    tick();
    scanStart = 1'b0;
    repeat (300) tick();
    checks++; if (aScanSum !== 26'd44551) begin failures++; $display("[TB] FAIL partial_sum: got %0d expected 44551", aScanSum); end
    rst_n = 1'b0;
    #1;
    checks++; if ({aScanBusy, aScanDone} !== 2'b00) begin failures++; $display("[TB] FAIL abort_flags: got %b expected 00", {aScanBusy, aScanDone}); end
    checks++; if (aScanSum !== '0) begin failures++; $display("[TB] FAIL abort_sum: got %0d expected 0", aScanSum); end
    checks++; if (aRspData !== 32'h0) begin failures++; $display("[TB] FAIL abort_rsp_data: got %h expected 0", aRspData); end
    checks++; if ({aRspValid, aRspErr, aReqReady} !== 6'b0) begin failures++; $display("[TB] FAIL abort_pulses: got %b expected 000000", {aRspValid, aRspErr, aReqReady}); end
    tick();
    rst_n = 1'b1;
    scanStart = 1'b1;
    #1;
    tick();
    scanStart = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      if (n > 0) tick();
      if (aScanDone) begin
        doneAt = n;
        break;
      end
    end
    checks++; if (doneAt !== 1026) begin failures++; $display("[TB] FAIL rescan_done_time: got %0d expected 1026", doneAt); end
    checks++; if (aScanSum !== 26'd523776) begin failures++; $display("[TB] FAIL rescan_sum: got %0d expected 523776", aScanSum); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_out_of_range();
    test_scan();
    test_req_during_scan();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
